// File: rtl/uart_tx_frame_pkg.sv
// uart_tx_frame_pkg
//   Shared UART transmit definitions: FSM state encoding, default data
//   width and the parity-mode values used by the receiver and register block.
package uart_tx_frame_pkg;

    localparam int UART_DATA_W = 8;

    // Encodings are kept identical to the legacy 3-bit header values.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5,
        ST_STOP2  = 3'd6
    } tx_state_e;

    // Value carried on parity_odd.
    typedef enum logic {
        PARITY_EVEN = 1'b0,
        PARITY_ODD  = 1'b1
    } parity_mode_e;

endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if
//   Byte handshake between the register block (master) and the UART
//   transmitter (slave).
//   tx_data    byte to send
//   tx_valid   tx_data valid
//   tx_ready   transmitter can accept a byte
//   parity_en  append parity bit
//   parity_odd 1 = odd parity, 0 = even
//   stop2      1 = two stop bits
interface uart_tx_frame_if
    import uart_tx_frame_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              parity_en;
    logic              parity_odd;
    logic              stop2;

    modport master (
        output tx_data, tx_valid, parity_en, parity_odd, stop2,
        input  tx_ready
    );

    modport slave (
        input  tx_data, tx_valid, parity_en, parity_odd, stop2,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_shreg.sv
// uart_tx_shreg
//   Data shift register and bit counter for the UART transmitter.
//   clk       system clock
//   rst       synchronous active-high reset
//   load      load load_data and clear the bit counter
//   shift     shift right (zero fill from MSB) and advance the counter
//   load_data byte to serialise
//   bit_next  value shreg[0] will hold after this cycle
//   last      counter is at the final data bit (DATA_W-1)
module uart_tx_shreg
    import uart_tx_frame_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] load_data,
    output logic              bit_next,
    output logic              last
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= load_data;
            cnt   <= '0;
        end else if (shift) begin
            shreg <= {1'b0, shreg[DATA_W-1:1]};
            if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Lets the parent register txd from the post-shift value.
    assign bit_next = shift ? shreg[1] : shreg[0];
    assign last     = (cnt == CNT_MAX);

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
//   Serialises one byte into a UART frame: start, DATA_W data bits LSB
//   first, optional parity, one or two stop bits.
//   clk        system clock
//   rst        synchronous active-high reset
//   baud_tick  one-clk strobe per bit period
//   tx_if      byte handshake (slave side): tx_data/tx_valid/tx_ready and
//              per-frame parity_en/parity_odd/stop2, sampled on acceptance
//   txd        registered serial line, idles high
//   tx_busy    frame in progress (state != IDLE)
//   tx_done    one-clk pulse on the tick ending the final stop bit
module uart_tx_frame
    import uart_tx_frame_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             baud_tick,
    uart_tx_frame_if.slave   tx_if,
    output logic             txd,
    output logic             tx_busy,
    output logic             tx_done
);
    tx_state_e state;
    tx_state_e state_nxt;

    logic [DATA_W-1:0] data_q;
    logic              par_en_q;
    logic              par_odd_q;
    logic              stop2_q;

    logic accept;
    logic shift;
    logic last;
    logic bit_next;
    logic parity;
    logic txd_nxt;

    assign tx_if.tx_ready = (state == ST_IDLE) & ~rst;
    assign accept         = tx_if.tx_valid & tx_if.tx_ready;
    assign tx_busy        = (state != ST_IDLE);
    assign parity         = (^data_q) ^ par_odd_q;

    uart_tx_shreg #(
        .DATA_W (DATA_W)
    ) u_shreg (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .shift     (shift),
        .load_data (tx_if.tx_data),
        .bit_next  (bit_next),
        .last      (last)
    );

    // Frame settings are frozen at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
        end else if (accept) begin
            data_q    <= tx_if.tx_data;
            par_en_q  <= tx_if.parity_en;
            par_odd_q <= tx_if.parity_odd;
            stop2_q   <= tx_if.stop2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            txd   <= 1'b1;
        end else begin
            state <= state_nxt;
            txd   <= txd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shift     = 1'b0;
        tx_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_ARM;
            end
            ST_ARM: begin
                if (baud_tick) state_nxt = ST_START;
            end
            ST_START: begin
                if (baud_tick) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (baud_tick) begin
                    shift = 1'b1;
                    if (last) state_nxt = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (baud_tick) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (stop2_q) begin
                        state_nxt = ST_STOP2;
                    end else begin
                        state_nxt = ST_IDLE;
                        tx_done   = ~rst;
                    end
                end
            end
            ST_STOP2: begin
                if (baud_tick) begin
                    state_nxt = ST_IDLE;
                    tx_done   = ~rst;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // txd is decoded from the next state so it changes on the ticking edge.
    always_comb begin
        txd_nxt = 1'b1;
        case (state_nxt)
            ST_START:  txd_nxt = 1'b0;
            ST_DATA:   txd_nxt = bit_next;
            ST_PARITY: txd_nxt = parity;
            default:   txd_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Baud generator, divider 4: tick on every fourth clk.
    logic [1:0] bcnt = 2'd0;
    logic       tick8;
    always @(posedge clk) bcnt <= bcnt + 2'd1;
    assign tick8 = (bcnt == 2'd3);

    // Divider 1: tick stuck high.
    logic tick5;
    assign tick5 = 1'b1;

    uart_tx_frame_if #(.DATA_W(8)) bus8 ();
    uart_tx_frame_if #(.DATA_W(5)) bus5 ();

    logic txd8, busy8, done8;
    logic txd5, busy5, done5;

    uart_tx_frame #(.DATA_W(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (tick8),
        .tx_if     (bus8.slave),
        .txd       (txd8),
        .tx_busy   (busy8),
        .tx_done   (done8)
    );

    uart_tx_frame #(.DATA_W(5)) dut5 (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (tick5),
        .tx_if     (bus5.slave),
        .txd       (txd5),
        .tx_busy   (busy5),
        .tx_done   (done5)
    );

    // Wait for an idle DUT (optionally a tick cycle), present the byte and
    // let the next posedge accept it. Returns negedges waited.
    task automatic accept8(input logic [7:0] d, input logic pen, input logic podd,
                           input logic s2, input bit on_tick, input bit keep,
                           input string tag, output int waited);
        bit found;
        found  = 1'b0;
        waited = 0;
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            waited++;
            if (bus8.tx_ready === 1'b1 && (!on_tick || tick8)) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s accept_wait: tx_ready never high, got %b expected 1", tag, bus8.tx_ready);
        end
        checks++;
        if (txd8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_outputs: got txd=%b busy=%b done=%b expected 1 0 0", tag, txd8, busy8, done8);
        end
        bus8.tx_data    = d;
        bus8.parity_en  = pen;
        bus8.parity_odd = podd;
        bus8.stop2      = s2;
        bus8.tx_valid   = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) bus8.tx_valid = 1'b0;
    endtask

    // Reference model: the frame is a list of line levels; the line idles
    // high until the first tick after acceptance, then steps one list entry
    // per tick. Checks txd/busy/done every cycle. Returns early (mid-bit)
    // when bit index abort_idx has been on the line for two cycles.
    task automatic monitor8(input logic [7:0] d, input logic pen, input logic podd,
                            input logic s2, input string tag, input int abort_idx);
        logic exp_bits[$];
        logic exp_txd, exp_done;
        int   idx, width;
        bit   finished;
        exp_bits = {};
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        if (pen) exp_bits.push_back((^d) ^ podd);
        exp_bits.push_back(1'b1);
        if (s2) exp_bits.push_back(1'b1);
        idx      = -1;
        width    = 0;
        finished = 1'b0;
        for (int g = 0; g < 400; g++) begin
            @(negedge clk);
            exp_txd  = (idx < 0) ? 1'b1 : exp_bits[idx];
            exp_done = tick8 && (idx == exp_bits.size() - 1);
            checks++;
            if (txd8 !== exp_txd) begin
                errors++;
                $display("FAIL %s txd slot %0d: got %b expected %b", tag, idx, txd8, exp_txd);
            end
            checks++;
            if (busy8 !== 1'b1) begin
                errors++;
                $display("FAIL %s tx_busy slot %0d: got %b expected 1", tag, idx, busy8);
            end
            checks++;
            if (done8 !== exp_done) begin
                errors++;
                $display("FAIL %s tx_done slot %0d: got %b expected %b", tag, idx, done8, exp_done);
            end
            width++;
            if (abort_idx >= 0 && idx == abort_idx && width == 2) begin
                finished = 1'b1;
                break;
            end
            if (tick8) begin
                if (idx == exp_bits.size() - 1) begin
                    finished = 1'b1;
                    break;
                end
                idx++;
                width = 0;
            end
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL %s frame_timeout: got no frame end, expected tx_done within 400 clks", tag);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (txd8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0 || bus8.tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset8: got txd=%b busy=%b done=%b ready=%b expected 1 0 0 0",
                     txd8, busy8, done8, bus8.tx_ready);
        end
        checks++;
        if (txd5 !== 1'b1 || busy5 !== 1'b0 || done5 !== 1'b0 || bus5.tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset5: got txd=%b busy=%b done=%b ready=%b expected 1 0 0 0",
                     txd5, busy5, done5, bus5.tx_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus8.tx_ready !== 1'b1 || bus5.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b/%b expected 1/1", bus8.tx_ready, bus5.tx_ready);
        end
    endtask

    task automatic test_8n1;
        int w;
        accept8(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "8N1", w);
        monitor8(8'hA5, 1'b0, 1'b0, 1'b0, "8N1", -1);
    endtask

    task automatic test_parity;
        int w;
        accept8(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "8E1", w);
        monitor8(8'hA5, 1'b1, 1'b0, 1'b0, "8E1", -1);
        accept8(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "8O2", w);
        monitor8(8'hA5, 1'b1, 1'b1, 1'b1, "8O2", -1);
    endtask

    task automatic test_back_to_back;
        int w;
        accept8(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "b2b_0", w);
        bus8.tx_data = 8'hFF;
        monitor8(8'h00, 1'b0, 1'b0, 1'b0, "b2b_0", -1);
        accept8(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_1", w);
        checks++;
        if (w !== 1) begin
            errors++;
            $display("FAIL b2b_gap: got acceptance %0d cycles after tx_done expected 1", w);
        end
        monitor8(8'hFF, 1'b0, 1'b0, 1'b0, "b2b_1", -1);
    endtask

    task automatic test_accept_on_tick;
        int w;
        accept8(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "acc_tick", w);
        monitor8(8'h3C, 1'b0, 1'b0, 1'b0, "acc_tick", -1);
    endtask

    task automatic test_reset_midframe;
        int w;
        accept8(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_mid", w);
        monitor8(8'h5A, 1'b0, 1'b0, 1'b0, "rst_mid", 4);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (txd8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0 || bus8.tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got txd=%b busy=%b done=%b ready=%b expected 1 0 0 0",
                     txd8, busy8, done8, bus8.tx_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0 || bus8.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_release: got done=%b ready=%b expected 0 1", done8, bus8.tx_ready);
        end
        accept8(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "after_rst", w);
        monitor8(8'h3C, 1'b0, 1'b0, 1'b0, "after_rst", -1);
    endtask

    // Random frames; the inputs are scrambled right after acceptance.
    task automatic test_random;
        int         w;
        logic [7:0] d;
        logic       pen, podd, s2;
        for (int n = 0; n < 5; n++) begin
            d    = 8'($urandom_range(0, 255));
            pen  = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            s2   = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            accept8(d, pen, podd, s2, 1'b0, 1'b0, $sformatf("rand%0d", n), w);
            bus8.tx_data    = ~d;
            bus8.parity_en  = ~pen;
            bus8.parity_odd = ~podd;
            bus8.stop2      = ~s2;
            monitor8(d, pen, podd, s2, $sformatf("rand%0d", n), -1);
        end
    endtask

    // DATA_W=5 with tick stuck high: one clk per bit.
    task automatic frame5(input logic [4:0] d, input string tag);
        logic exp_bits[$];
        bit   found;
        exp_bits = {};
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 5; i++) exp_bits.push_back(d[i]);
        exp_bits.push_back(1'b1);
        found = 1'b0;
        for (int g = 0; g < 20; g++) begin
            @(negedge clk);
            if (bus5.tx_ready === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s accept_wait: tx_ready got %b expected 1", tag, bus5.tx_ready);
        end
        bus5.tx_data    = d;
        bus5.parity_en  = 1'b0;
        bus5.parity_odd = 1'b0;
        bus5.stop2      = 1'b0;
        bus5.tx_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus5.tx_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (txd5 !== 1'b1 || busy5 !== 1'b1 || done5 !== 1'b0) begin
            errors++;
            $display("FAIL %s arm: got txd=%b busy=%b done=%b expected 1 1 0", tag, txd5, busy5, done5);
        end
        for (int k = 0; k < exp_bits.size(); k++) begin
            @(negedge clk);
            checks++;
            if (txd5 !== exp_bits[k] || done5 !== (k == exp_bits.size() - 1) || busy5 !== 1'b1) begin
                errors++;
                $display("FAIL %s bit%0d: got txd=%b done=%b busy=%b expected %b %b 1",
                         tag, k, txd5, done5, busy5, exp_bits[k], (k == exp_bits.size() - 1));
            end
        end
        @(negedge clk);
        checks++;
        if (txd5 !== 1'b1 || busy5 !== 1'b0 || done5 !== 1'b0 || bus5.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s end: got txd=%b busy=%b done=%b ready=%b expected 1 0 0 1",
                     tag, txd5, busy5, done5, bus5.tx_ready);
        end
    endtask

    task automatic test_w5_tick_high;
        frame5(5'h15, "5N1_15");
        frame5(5'($urandom_range(0, 31)), "5N1_rand0");
        frame5(5'($urandom_range(0, 31)), "5N1_rand1");
    endtask

    initial begin
        rst             = 1'b1;
        bus8.tx_data    = '0;
        bus8.tx_valid   = 1'b0;
        bus8.parity_en  = 1'b0;
        bus8.parity_odd = 1'b0;
        bus8.stop2      = 1'b0;
        bus5.tx_data    = '0;
        bus5.tx_valid   = 1'b0;
        bus5.parity_en  = 1'b0;
        bus5.parity_odd = 1'b0;
        bus5.stop2      = 1'b0;

        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_accept_on_tick();
        test_reset_midframe();
        test_random();
        test_w5_tick_high();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
